// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : regfile_pkg                                          |
// | Description : Shared defaults and types for the multi-port integer |
// |               register file and its busy scoreboard.               |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int DEPTH_DEF = 32;
   localparam int AW_DEF    = $clog2(DEPTH_DEF);

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : regfile_scoreboard                                   |
// | Description : Per-register busy bits. Allocation sets, writeback   |
// |               clears, allocation wins a same-cycle collision.      |
// |               Also reports the busy bit seen by each read port.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_RD*AW-1:0] rd_addr_i,
   input  logic [NUM_WR-1:0]    wr_en_i,
   input  logic [NUM_WR*AW-1:0] wr_addr_i,
   input  logic                 alloc_en_i,
   input  logic [AW-1:0]        alloc_addr_i,
   output logic [NUM_RD-1:0]    rd_busy_o,
   output logic [DEPTH-1:0]     busy_vec_o
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Next busy state: writebacks clear first, then allocation overrides.
   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_en_i[j]) begin
            busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
         end
      end
      if (alloc_en_i) begin
         busy_d[alloc_addr_i] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   // Busy register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec_o = busy_q;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
      logic hit;

      // A same-cycle write to the read address makes the data available now.
      always_comb begin
         hit = 1'b0;
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i[i*AW +: AW])) begin
                  hit = 1'b1;
               end
            end
         end
      end

      assign rd_busy_o[i] = busy_q[rd_addr_i[i*AW +: AW]] & ~hit;
   end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : regfile_mp                                           |
// | Description : Parametrised multi-port integer register file with   |
// |               optional hard-wired zero register, write-to-read     |
// |               bypass and a per-register busy scoreboard.           |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_RD*AW-1:0]   rd_addr_i,
   output logic [NUM_RD*XLEN-1:0] rd_data_o,
   output logic [NUM_RD-1:0]      rd_busy_o,
   input  logic [NUM_WR-1:0]      wr_en_i,
   input  logic [NUM_WR*AW-1:0]   wr_addr_i,
   input  logic [NUM_WR*XLEN-1:0] wr_data_i,
   input  logic                   alloc_en_i,
   input  logic [AW-1:0]          alloc_addr_i,
   output logic [DEPTH-1:0]       busy_vec_o
);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] mem_d [DEPTH];

   logic [AW-1:0]   w_rd_addr [NUM_RD];
   logic [AW-1:0]   w_wr_addr [NUM_WR];
   logic [XLEN-1:0] w_wr_data [NUM_WR];

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
      assign w_rd_addr[i] = rd_addr_i[i*AW +: AW];
   end

   for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
      assign w_wr_addr[j] = wr_addr_i[j*AW +: AW];
      assign w_wr_data[j] = wr_data_i[j*XLEN +: XLEN];
   end

   // Apply writes in ascending port order so the highest port wins a conflict.
   always_comb begin
      mem_d = mem_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_en_i[j] && !((ZERO_REG != 0) && (w_wr_addr[j] == '0))) begin
            mem_d[w_wr_addr[j]] = w_wr_data[j];
         end
      end
   end

   // Storage array with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem_q[r] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [XLEN-1:0] rd_val;
      logic            zero_hit;

      assign zero_hit = (ZERO_REG != 0) && (w_rd_addr[i] == '0);

      // Stored value, overridden by the highest matching same-cycle write.
      always_comb begin
         if (zero_hit) begin
            rd_val = '0;
         end else begin
            rd_val = mem_q[w_rd_addr[i]];
         end
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en_i[j] && (w_wr_addr[j] == w_rd_addr[i]) && !zero_hit) begin
                  rd_val = w_wr_data[j];
               end
            end
         end
      end

      assign rd_data_o[i*XLEN +: XLEN] = rd_val;
   end

   regfile_scoreboard #(
      .DEPTH    (DEPTH),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .AW       (AW)
   ) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .rd_addr_i    (rd_addr_i),
      .wr_en_i      (wr_en_i),
      .wr_addr_i    (wr_addr_i),
      .alloc_en_i   (alloc_en_i),
      .alloc_addr_i (alloc_addr_i),
      .rd_busy_o    (rd_busy_o),
      .busy_vec_o   (busy_vec_o)
   );

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, two-read file in the pipelined core.
- Adds configurable width, depth, read ports and write ports, plus write-to-read bypass.
- Adds a per-register busy scoreboard so the issue stage can detect pending writes.
- Sits between decode/issue (reads, allocation) and writeback (writes, busy clear).

Parameters:
XLEN, 32, data width in bits
DEPTH, 32, number of architectural registers (power of two, >= 2)
NUM_RD, 2, read ports
NUM_WR, 2, write ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
(derived) AW = $clog2(DEPTH)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
rd_addr  in  NUM_RD*AW  read addresses; port i = bits [i*AW +: AW]
rd_data  out  NUM_RD*XLEN  read data, combinational
rd_busy  out  NUM_RD  busy bit of each read address, combinational, post-bypass
wr_en  in  NUM_WR  write enables
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*XLEN  write data
alloc_en  in  1  mark alloc_addr busy (new producer issued)
alloc_addr  in  AW  register to mark busy
busy_vec  out  DEPTH  full scoreboard, registered

Behaviour:
- Reset: when rst is sampled high, all registers go to 0 and busy_vec to 0 on that edge. Reset wins over any same-cycle write or alloc. With rst held high, rd_data reads 0 (bypass of wr_data still applies if BYPASS=1; the bench must not rely on writes during rst).
- Write: on posedge, for each port j with wr_en[j], mem[wr_addr[j]] <= wr_data[j]. Write latency is 1 cycle.
- Write conflict: if two ports write the same address, the highest-index port wins. This is deterministic and not an error.
- ZERO_REG=1: writes to address 0 are dropped, reads of address 0 return 0, busy[0] is held at 0, and alloc of 0 is ignored.
- Read without bypass: rd_data[i] = mem[rd_addr[i]] (or 0 per ZERO_REG). Purely combinational.
- Read with BYPASS=1: if any enabled write port matches rd_addr[i] this cycle, return that wr_data, using the highest-index match. Otherwise return mem.
- Scoreboard, next-state of busy[r]:
  - set if alloc_en && alloc_addr==r;
  - else clear if any wr_en[j] && wr_addr[j]==r;
  - else hold.
- Alloc and write to the same register in one cycle: alloc wins, so the register stays busy. The write completes the old producer; the new producer is still pending. Data is still written.
- rd_busy[i]:
  - Equals busy[rd_addr[i]], except it is forced 0 when BYPASS=1 and a same-cycle write matches (data is available now).
  - alloc_en in the same cycle does not affect rd_busy until the next cycle.
- Addresses are always in range because DEPTH is a power of two, so there is no wrap handling.
- No X on outputs after the first reset edge. Pre-reset memory contents are undefined and there is no file preload.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN/DEPTH constants;
  - typedef reg_addr_t = logic [AW-1:0] for the default depth;
  - typedef xlen_t.
- One sub-module, regfile_scoreboard, implements the busy vector and the set/clear priority and drives rd_busy. Storage and bypass muxing stay in regfile_mp.
- Port unpacking uses generate loops; no other sub-modules.

Test Plan:
1. Reset, then write port 0 addr 5 = 0xDEADBEEF; next cycle read port 1 addr 5 -> 0xDEADBEEF. Assert rst mid-run -> next cycle read addr 5 = 0 and busy_vec = 0.
2. ZERO_REG: write addr 0 = 0x1234 and alloc addr 0 -> read addr 0 = 0, busy_vec[0] = 0.
3. Conflict and bypass: same cycle wr0 addr 7 = 0xAAAA0000, wr1 addr 7 = 0x5555FFFF, read addr 7 -> rd_data = 0x5555FFFF combinationally; next cycle mem[7] = 0x5555FFFF.
4. Scoreboard:
   - alloc addr 9 -> next cycle busy_vec[9] = 1, rd_busy = 1 for a reader of 9;
   - write addr 9 = 0x42 -> rd_busy = 0 in that cycle (bypass), data 0x42;
   - next cycle busy_vec[9] = 0.
5. Alloc addr 3 and write addr 3 = 0x77 in the same cycle, with busy[3] = 1 beforehand -> next cycle busy_vec[3] = 1 and mem[3] = 0x77.
6. Parameter sweep: NUM_RD=4, NUM_WR=1, DEPTH=64, BYPASS=0 -> write addr 63 = 0xCAFEF00D; a same-cycle read returns the old value 0; the next cycle all four ports reading 63 return 0xCAFEF00D.
